// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF vote controller and its counter bank.
package puf_pkg;

  localparam int PUF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width needed to hold a count from 0 up to and including votes.
  function automatic int cnt_width(input int votes);
    return (votes < 1) ? 1 : $clog2(votes + 1);
  endfunction

endpackage

// File: rtl/puf_vote_counter.sv
// Per-bit sample counters with combinational majority and non-unanimity outputs.
module puf_vote_counter
  import puf_pkg::*;
#(
  parameter int WIDTH = PUF_WIDTH,
  parameter int VOTES = 7,
  parameter int CW    = cnt_width(VOTES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] majority,
  output logic [WIDTH-1:0] unstable
);

  logic [CW-1:0] cnt [WIDTH];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt[i] + CW'(sample[i]);
    end
  end

  always_comb begin
    majority = '0;
    unstable = '0;
    for (int i = 0; i < WIDTH; i++) begin
      majority[i] = (cnt[i] > CW'(VOTES / 2));
      unstable[i] = (cnt[i] != '0) && (cnt[i] != CW'(VOTES));
    end
  end

endmodule

// File: rtl/puf_vote_ctrl.sv
// Sequences VOTES launch/sample cycles on the PUF array and returns the majority-voted response.
//   state | meaning
//   IDLE  | waiting for a challenge; req_ready high
//   SETUP | pulse low, challenge settling / arbiters recovering
//   EVAL  | pulse high, race in flight; sample on the last cycle
//   DONE  | first cycle latches the vote, then holds result until taken
module puf_vote_ctrl
  import puf_pkg::*;
#(
  parameter int WIDTH      = PUF_WIDTH,
  parameter int VOTES      = 7,
  parameter int SETUP_CYC  = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_challenge,
  output logic             puf_pulse,
  output logic [WIDTH-1:0] puf_challenge,
  input  logic [WIDTH-1:0] puf_response,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_response,
  output logic [WIDTH-1:0] rsp_unstable
);

  if ((VOTES < 1) || (VOTES % 2 == 0) || (SETUP_CYC < 1) || (SETTLE_CYC < 1)) begin : g_bad_param
    $error("puf_vote_ctrl: VOTES must be odd and >= 1, SETUP_CYC and SETTLE_CYC >= 1");
  end

  localparam int TMAX = (SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int VW   = cnt_width(VOTES);

  state_t            state;
  logic [TW-1:0]     timer;
  logic [VW-1:0]     vote_idx;
  logic              cnt_clr;
  logic              cnt_en;
  logic [WIDTH-1:0]  majority;
  logic [WIDTH-1:0]  unstable;

  assign req_ready = (state == IDLE);
  assign cnt_clr   = (state == IDLE) && req_valid;
  assign cnt_en    = (state == EVAL) && (timer == '0);

  puf_vote_counter #(
    .WIDTH (WIDTH),
    .VOTES (VOTES),
    .CW    (VW)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .sample   (puf_response),
    .majority (majority),
    .unstable (unstable)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      vote_idx      <= '0;
      puf_pulse     <= 1'b0;
      puf_challenge <= '0;
      rsp_valid     <= 1'b0;
      rsp_response  <= '0;
      rsp_unstable  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            puf_challenge <= req_challenge;
            vote_idx      <= '0;
            timer         <= TW'(SETUP_CYC - 1);
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (timer == '0) begin
            puf_pulse <= 1'b1;
            timer     <= TW'(SETTLE_CYC - 1);
            state     <= EVAL;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        EVAL: begin
          if (timer == '0) begin
            puf_pulse <= 1'b0;
            vote_idx  <= vote_idx + VW'(1);
            if (vote_idx == VW'(VOTES - 1)) begin
              state <= DONE;
            end else begin
              timer <= TW'(SETUP_CYC - 1);
              state <= SETUP;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DONE: begin
          // Counts include the final sample only from this cycle on, so latch here.
          if (!rsp_valid) begin
            rsp_valid    <= 1'b1;
            rsp_response <= majority;
            rsp_unstable <= unstable;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_vote_ctrl.sv
// Directed bench for puf_vote_ctrl: vector table plus hand-written backpressure, abort and small-build cases.
module tb_puf_vote_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [15:0] req_challenge;
  logic        puf_pulse;
  logic [15:0] puf_challenge, puf_response;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_response, rsp_unstable;

  logic        req_valid_b, req_ready_b, puf_pulse_b, rsp_valid_b, rsp_ready_b;
  logic [15:0] req_challenge_b, puf_challenge_b, rsp_response_b, rsp_unstable_b;
  logic [15:0] puf_response_b;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  puf_vote_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_challenge(req_challenge),
    .puf_pulse(puf_pulse), .puf_challenge(puf_challenge), .puf_response(puf_response),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_response(rsp_response), .rsp_unstable(rsp_unstable)
  );

  puf_vote_ctrl #(.WIDTH(16), .VOTES(1), .SETUP_CYC(1), .SETTLE_CYC(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_challenge(req_challenge_b),
    .puf_pulse(puf_pulse_b), .puf_challenge(puf_challenge_b), .puf_response(puf_response_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_response(rsp_response_b), .rsp_unstable(rsp_unstable_b)
  );

  // PUF array model: k counts completed pulses since the current request was issued.
  int          mode = 0;
  int          k = 0;
  logic [15:0] cval = '0;

  always_comb begin
    puf_response = '0;
    case (mode)
      0: puf_response = cval;
      1: puf_response = {(k < 3), 14'b0, (k < 4)};
      2: puf_response = k[0] ? 16'hFFFF : 16'h0000;
      3: puf_response = (k < 6) ? 16'hFFFF : 16'h0000;
      4: puf_response = (k == 0) ? 16'h00F0 : 16'h0000;
      5: puf_response = puf_challenge ^ 16'h5500;
      default: puf_response = '0;
    endcase
  end

  assign puf_response_b = 16'hBEEF;

  // Pulse-shape and challenge-stability monitor.
  logic        pulse_d = 1'b0;
  logic [15:0] chal_d = '0;
  int hi_len = 0, lo_len = 100, runs = 0, bad_runs = 0, chal_bad = 0;

  always @(negedge clk) begin
    if (puf_pulse) begin
      if (!pulse_d) begin
        if (lo_len < 2) bad_runs++;
        hi_len = 0;
      end
      hi_len++;
    end else begin
      if (pulse_d) begin
        runs++;
        k++;
        if (hi_len != 4) bad_runs++;
        lo_len = 0;
      end
      lo_len++;
    end
    if ((puf_challenge != chal_d) && (puf_pulse || pulse_d)) chal_bad++;
    pulse_d = puf_pulse;
    chal_d  = puf_challenge;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake(input string nm);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({nm, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    chk({nm, " back to idle"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run_req(input logic [15:0] c, input logic [15:0] er, input logic [15:0] eu,
                         input string nm);
    int n;
    k = 0; runs = 0; bad_runs = 0; chal_bad = 0;
    req_valid = 1'b1;
    req_challenge = c;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({nm, " accepted"}, 32'(req_ready), 32'd0);
    wait_rsp(n);
    chk({nm, " latency"}, 32'(n), 32'd43);
    chk({nm, " response"}, 32'(rsp_response), 32'(er));
    chk({nm, " unstable"}, 32'(rsp_unstable), 32'(eu));
    chk({nm, " pulse runs"}, 32'(runs), 32'd7);
    chk({nm, " pulse shape"}, 32'(bad_runs), 32'd0);
    chk({nm, " challenge held"}, 32'(puf_challenge), 32'(c));
    chk({nm, " challenge stable in pulse"}, 32'(chal_bad), 32'd0);
    handshake(nm);
  endtask

  typedef struct {
    logic [15:0] chal;
    int          mode;
    logic [15:0] cval;
    logic [15:0] er;
    logic [15:0] eu;
    string       name;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    logic [15:0] held_r, held_u;

    vecs[0] = '{16'hA5C3, 0, 16'h1234, 16'h1234, 16'h0000, "stable_1234"};
    vecs[1] = '{16'h0F0F, 1, 16'h0000, 16'h0001, 16'h8001, "noisy_4of7_3of7"};
    vecs[2] = '{16'h1111, 2, 16'h0000, 16'h0000, 16'hFFFF, "alt_3of7"};
    vecs[3] = '{16'h2222, 3, 16'h0000, 16'hFFFF, 16'hFFFF, "six_of_7"};
    vecs[4] = '{16'h3333, 4, 16'h0000, 16'h0000, 16'h00F0, "one_of_7"};
    vecs[5] = '{16'h4444, 0, 16'hFFFF, 16'hFFFF, 16'h0000, "stable_ffff"};

    rst = 1'b1;
    req_valid = 1'b0; req_challenge = '0; rsp_ready = 1'b0;
    req_valid_b = 1'b0; req_challenge_b = '0; rsp_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset puf_pulse", 32'(puf_pulse), 32'd0);
    chk("reset puf_challenge", 32'(puf_challenge), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_response", 32'(rsp_response), 32'd0);
    chk("reset rsp_unstable", 32'(rsp_unstable), 32'd0);

    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      cval = vecs[i].cval;
      run_req(vecs[i].chal, vecs[i].er, vecs[i].eu, vecs[i].name);
    end

    // Backpressure with a request waiting behind the held result.
    mode = 0; cval = 16'h1234;
    k = 0;
    req_valid = 1'b1; req_challenge = 16'hA5C3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(n);
    chk("bp latency", 32'(n), 32'd43);
    held_r = rsp_response;
    held_u = rsp_unstable;
    chk("bp response", 32'(held_r), 32'h1234);
    req_valid = 1'b1; req_challenge = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp hold valid", 32'(rsp_valid), 32'd1);
      chk("bp hold data", {rsp_response, rsp_unstable}, {held_r, held_u});
      chk("bp req_ready low", 32'(req_ready), 32'd0);
    end
    k = 0; cval = 16'hFFFF;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp handshake", 32'(rsp_valid), 32'd0);
    chk("bp idle one cycle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp next accepted", 32'(req_ready), 32'd0);
    chk("bp next challenge", 32'(puf_challenge), 32'hFFFF);
    wait_rsp(n);
    chk("bp next latency", 32'(n), 32'd43);
    chk("bp next response", 32'(rsp_response), 32'hFFFF);
    handshake("bp next");

    // Abort during the third pulse.
    mode = 0; cval = 16'h1234; k = 0;
    req_valid = 1'b1; req_challenge = 16'h5A5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!(k == 2 && puf_pulse) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort reached 3rd eval", 32'(n < 200), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort pulse low", 32'(puf_pulse), 32'd0);
    chk("abort req_ready", 32'(req_ready), 32'd1);
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    mode = 0; cval = 16'h00FF;
    run_req(16'h00FF, 16'h00FF, 16'h0000, "after_abort");

    // Back-to-back: second request held on req_valid while the first runs.
    mode = 5; k = 0; chal_bad = 0;
    req_valid = 1'b1; req_challenge = 16'h0001;
    @(posedge clk); #1;
    req_challenge = 16'h0002;
    chk("b2b first accepted", 32'(puf_challenge), 32'h0001);
    wait_rsp(n);
    chk("b2b first latency", 32'(n), 32'd43);
    chk("b2b first response", 32'(rsp_response), 32'h5501);
    chk("b2b first unstable", 32'(rsp_unstable), 32'h0000);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b second accepted", 32'(puf_challenge), 32'h0002);
    wait_rsp(n);
    chk("b2b second latency", 32'(n), 32'd43);
    chk("b2b second response", 32'(rsp_response), 32'h5502);
    chk("b2b challenge only changes with pulse low", 32'(chal_bad), 32'd0);
    handshake("b2b second");

    // Minimal build: VOTES=1, SETUP_CYC=1, SETTLE_CYC=1.
    chk("small reset ready", 32'(req_ready_b), 32'd1);
    req_valid_b = 1'b1; req_challenge_b = 16'hC0DE;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    chk("small accepted", 32'(req_ready_b), 32'd0);
    n = 0;
    while (!rsp_valid_b && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("small latency", 32'(n), 32'd3);
    chk("small response", 32'(rsp_response_b), 32'hBEEF);
    chk("small unstable", 32'(rsp_unstable_b), 32'h0000);
    rsp_ready_b = 1'b1;
    @(posedge clk); #1;
    rsp_ready_b = 1'b0;
    chk("small handshake", 32'(rsp_valid_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
